// File: rtl/sec32_encoder_pkg.sv
// Shared widths, codeword bit positions and injection-FSM states for the SEC(40,32) encoder.
// S1 holds the data plus its nibble (group) and column parities; S2 holds the finished codeword.
package sec32_encoder_pkg;

   localparam int DATA_W   = 32;
   localparam int CHK_W    = 8;
   localparam int CW_W     = DATA_W + CHK_W;
   localparam int GRP_N    = 8;
   localparam int POS_W    = 6;
   localparam int CHK_BASE = DATA_W;   // codeword index of c0; c[k] sits at CHK_BASE+k

   typedef enum logic [1:0] {
      INJ_IDLE,
      INJ_ARMED,
      INJ_APPLY
   } inj_state_e;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [GRP_N-1:0]  grp;
      logic [GRP_N-1:0]  col;
   } s1_t;

   // Positions at or beyond the codeword width select no bit at all.
   function automatic logic [CW_W-1:0] flip_mask(input logic [POS_W-1:0] pos);
      logic [CW_W-1:0] m;
      m = '0;
      if (pos < POS_W'(CW_W)) begin
         m = CW_W'(1) << pos;
      end
      return m;
   endfunction

endpackage

// File: rtl/sec32_encoder_if.sv
// Encoder stream, injection-control and status signals bundled for the source (master) and encoder (slave).
// Both streams use valid/ready; a transfer happens when valid and ready are high on the same edge.
interface sec32_encoder_if
   import sec32_encoder_pkg::*;
#(
   parameter int CNT_W = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CHK_W-1:0]  out_check;
   logic              inj_arm;
   logic [POS_W-1:0]  inj_pos;
   logic              inj_busy;
   logic [CNT_W-1:0]  word_cnt;

   modport master (
      output in_valid, in_data, out_ready, inj_arm, inj_pos,
      input  in_ready, out_valid, out_data, out_check, inj_busy, word_cnt
   );

   modport slave (
      input  in_valid, in_data, out_ready, inj_arm, inj_pos,
      output in_ready, out_valid, out_data, out_check, inj_busy, word_cnt
   );

endinterface

// File: rtl/sec32_parity.sv
// Combinational SEC check generator split at the S1 boundary: data -> nibble/column parities,
// then stored parities -> c[7:0]. No state, no latency, no backpressure.
module sec32_parity
   import sec32_encoder_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   output logic [GRP_N-1:0]  grp,
   output logic [GRP_N-1:0]  col,
   input  logic [GRP_N-1:0]  grp_in,
   input  logic [GRP_N-1:0]  col_in,
   output logic [CHK_W-1:0]  check
);

   // grp[n] covers nibble n; col[j] / col[4+j] cover bit j of each nibble in the low / high half.
   always_comb begin
      grp = '0;
      col = '0;
      for (int n = 0; n < GRP_N; n++) begin
         grp[n] = ^data[4*n +: 4];
      end
      for (int j = 0; j < 4; j++) begin
         col[j]   = data[j]    ^ data[4+j]  ^ data[8+j]  ^ data[12+j];
         col[4+j] = data[16+j] ^ data[20+j] ^ data[24+j] ^ data[28+j];
      end
   end

   assign check[0] = grp_in[4] ^ grp_in[5] ^ col_in[0];
   assign check[1] = grp_in[6] ^ grp_in[7] ^ col_in[1];
   assign check[2] = grp_in[4] ^ grp_in[6] ^ col_in[2];
   assign check[3] = grp_in[5] ^ grp_in[7] ^ col_in[3];
   assign check[4] = grp_in[0] ^ grp_in[1] ^ col_in[4];
   assign check[5] = grp_in[2] ^ grp_in[3] ^ col_in[5];
   assign check[6] = grp_in[0] ^ grp_in[2] ^ col_in[6];
   assign check[7] = grp_in[1] ^ grp_in[3] ^ col_in[7];

endmodule

// File: rtl/sec32_encoder.sv
// Two-stage SEC(40,32) encoder with single-bit error injection; 2-cycle latency, one word per cycle.
// Each stage refills when empty or draining; a stalled output holds its codeword until accepted.
module sec32_encoder
   import sec32_encoder_pkg::*;
#(
   parameter int CNT_W = 16
)
(
   input logic            clk,
   input logic            rst,
   sec32_encoder_if.slave bus
);

   logic              s1_vld_q, s1_vld_d;
   s1_t               s1_q, s1_d;
   logic              s2_vld_q, s2_vld_d;
   logic [DATA_W-1:0] s2_data_q, s2_data_d;
   logic [CHK_W-1:0]  s2_chk_q, s2_chk_d;
   inj_state_e        inj_state_q, inj_state_d;
   logic [POS_W-1:0]  inj_pos_q, inj_pos_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [GRP_N-1:0]  grp, col;
   logic [CHK_W-1:0]  chk;
   logic [CW_W-1:0]   flip;
   logic              s2_adv, s2_load, in_rdy, in_acc, out_fire;

   sec32_parity u_parity (
      .data   (bus.in_data),
      .grp    (grp),
      .col    (col),
      .grp_in (s1_q.grp),
      .col_in (s1_q.col),
      .check  (chk)
   );

   assign s2_adv   = !s2_vld_q || bus.out_ready;
   assign s2_load  = s1_vld_q && s2_adv;
   assign in_rdy   = !s1_vld_q || s2_adv;
   assign in_acc   = bus.in_valid && in_rdy;
   assign out_fire = s2_vld_q && bus.out_ready;
   assign flip     = (inj_state_q == INJ_ARMED) ? flip_mask(inj_pos_q) : '0;

   always_comb begin
      s1_vld_d  = s1_vld_q;
      s1_d      = s1_q;
      s2_vld_d  = s2_vld_q;
      s2_data_d = s2_data_q;
      s2_chk_d  = s2_chk_q;
      cnt_d     = cnt_q;
      if (in_rdy) begin
         s1_vld_d = bus.in_valid;
      end
      if (in_acc) begin
         s1_d = '{data: bus.in_data, grp: grp, col: col};
      end
      if (s2_adv) begin
         s2_vld_d = s1_vld_q;
      end
      if (s2_load) begin
         {s2_chk_d, s2_data_d} = {chk, s1_q.data} ^ flip;
      end
      if (out_fire && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // The flipped word is the one sitting in S2 while APPLY, so its delivery ends the injection.
   always_comb begin
      inj_state_d = inj_state_q;
      inj_pos_d   = inj_pos_q;
      case (inj_state_q)
         INJ_IDLE: begin
            if (bus.inj_arm) begin
               inj_state_d = INJ_ARMED;
               inj_pos_d   = bus.inj_pos;
            end
         end
         INJ_ARMED: begin
            if (s2_load) begin
               inj_state_d = INJ_APPLY;
            end
         end
         INJ_APPLY: begin
            if (out_fire) begin
               inj_state_d = INJ_IDLE;
            end
         end
         default: inj_state_d = INJ_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q    <= 1'b0;
         s1_q        <= '0;
         s2_vld_q    <= 1'b0;
         s2_data_q   <= '0;
         s2_chk_q    <= '0;
         inj_state_q <= INJ_IDLE;
         inj_pos_q   <= '0;
         cnt_q       <= '0;
      end else begin
         s1_vld_q    <= s1_vld_d;
         s1_q        <= s1_d;
         s2_vld_q    <= s2_vld_d;
         s2_data_q   <= s2_data_d;
         s2_chk_q    <= s2_chk_d;
         inj_state_q <= inj_state_d;
         inj_pos_q   <= inj_pos_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = s2_vld_q;
   assign bus.out_data  = s2_data_q;
   assign bus.out_check = s2_chk_q;
   assign bus.inj_busy  = (inj_state_q != INJ_IDLE);
   assign bus.word_cnt  = cnt_q;

endmodule

// File: tb/tb_sec32_encoder.sv
// Self-checking bench for sec32_encoder: directed vectors plus a random stream scored against
// a reference built straight from the check-bit equations, with a behavioural SEC decoder.
module tb_sec32_encoder;

   logic clk;
   logic rst;

   sec32_encoder_if #(.CNT_W(16)) bus ();
   sec32_encoder_if #(.CNT_W(3))  bus2 ();

   sec32_encoder #(.CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   sec32_encoder #(.CNT_W(3)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      logic [31:0] orig;
      logic [31:0] d;
      logic [7:0]  c;
      logic        inj;
   } sb_t;

   sb_t         sb[$];
   int          n_chk = 0;
   int          n_bad = 0;
   logic        m_busy;
   logic        pend;
   logic [5:0]  pend_pos;
   logic [15:0] m_cnt;
   logic        prev_stall;
   logic [39:0] prev_word;
   logic        got_out, got_acc, last_rdy;
   logic [7:0]  last_chk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] ref_check(input logic [31:0] d);
      logic [7:0] c;
      c[0] = (^d[23:16]) ^ d[0] ^ d[4] ^ d[8]  ^ d[12];
      c[1] = (^d[31:24]) ^ d[1] ^ d[5] ^ d[9]  ^ d[13];
      c[2] = (^d[19:16]) ^ (^d[27:24]) ^ d[2] ^ d[6] ^ d[10] ^ d[14];
      c[3] = (^d[23:20]) ^ (^d[31:28]) ^ d[3] ^ d[7] ^ d[11] ^ d[15];
      c[4] = (^d[7:0])   ^ d[16] ^ d[20] ^ d[24] ^ d[28];
      c[5] = (^d[15:8])  ^ d[17] ^ d[21] ^ d[25] ^ d[29];
      c[6] = (^d[3:0])   ^ (^d[11:8])  ^ d[18] ^ d[22] ^ d[26] ^ d[30];
      c[7] = (^d[7:4])   ^ (^d[15:12]) ^ d[19] ^ d[23] ^ d[27] ^ d[31];
      return c;
   endfunction

   // Syndrome matched against each data column; a check-bit-only syndrome leaves data as is.
   function automatic logic [31:0] sec_decode(input logic [31:0] d, input logic [7:0] c);
      logic [7:0]  syn;
      logic [31:0] r;
      syn = ref_check(d) ^ c;
      r   = d;
      if (syn != 8'h00) begin
         for (int k = 0; k < 32; k++) begin
            if (ref_check(32'h1 << k) == syn) r = d ^ (32'h1 << k);
         end
      end
      return r;
   endfunction

   task automatic model_reset();
      sb.delete();
      m_busy     = 1'b0;
      pend       = 1'b0;
      pend_pos   = '0;
      m_cnt      = '0;
      prev_stall = 1'b0;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      bus.inj_arm   = 1'b0;
      bus.inj_pos   = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // One cycle: drive after the falling edge, score 1 ns later, then advance to the next falling edge.
   task automatic step(input logic iv, input logic [31:0] id, input logic ordy,
                       input logic arm, input logic [5:0] pos);
      sb_t         e;
      logic        busy_now;
      logic [39:0] m;
      bus.in_valid  = iv;
      bus.in_data   = id;
      bus.out_ready = ordy;
      bus.inj_arm   = arm;
      bus.inj_pos   = pos;
      #1;
      busy_now = m_busy;
      chk("inj_busy", 64'(bus.inj_busy), 64'(m_busy));
      chk("word_cnt", 64'(bus.word_cnt), 64'(m_cnt));
      if (prev_stall) begin
         chk("hold_valid", 64'(bus.out_valid), 64'd1);
         chk("hold_word", 64'({bus.out_check, bus.out_data}), 64'(prev_word));
      end
      got_out  = 1'b0;
      got_acc  = 1'b0;
      last_rdy = bus.in_ready;
      if (bus.out_valid && ordy) begin
         got_out  = 1'b1;
         last_chk = bus.out_check;
         if (sb.size() == 0) begin
            chk("spurious_out", 64'(bus.out_valid), 64'd0);
         end else begin
            e = sb.pop_front();
            chk("out_data", 64'(bus.out_data), 64'(e.d));
            chk("out_check", 64'(bus.out_check), 64'(e.c));
            chk("decoded", 64'(sec_decode(bus.out_data, bus.out_check)), 64'(e.orig));
            if (e.inj) m_busy = 1'b0;
            if (m_cnt != 16'hFFFF) m_cnt++;
         end
      end
      if (arm && !busy_now) begin
         m_busy   = 1'b1;
         pend     = 1'b1;
         pend_pos = pos;
      end
      if (iv && bus.in_ready) begin
         got_acc = 1'b1;
         m       = '0;
         e.inj   = 1'b0;
         if (pend) begin
            if (pend_pos < 6'd40) m = 40'(1) << pend_pos;
            e.inj = 1'b1;
            pend  = 1'b0;
         end
         e.orig = id;
         e.d    = id ^ m[31:0];
         e.c    = ref_check(id) ^ m[39:32];
         sb.push_back(e);
      end
      prev_stall = bus.out_valid && !ordy;
      prev_word  = {bus.out_check, bus.out_data};
      @(negedge clk);
   endtask

   logic [31:0] vec_d [3];
   logic [7:0]  vec_c [3];
   logic [31:0] w [5];
   int          idx;
   int          sent;
   int          n2;

   initial begin
      rst            = 1'b1;
      bus2.in_valid  = 1'b0;
      bus2.in_data   = '0;
      bus2.out_ready = 1'b0;
      bus2.inj_arm   = 1'b0;
      bus2.inj_pos   = '0;
      @(negedge clk);
      do_reset();

      #1;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_data", 64'(bus.out_data), 64'd0);
      chk("rst_out_check", 64'(bus.out_check), 64'd0);
      chk("rst_word_cnt", 64'(bus.word_cnt), 64'd0);
      chk("rst_inj_busy", 64'(bus.inj_busy), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);

      vec_d[0] = 32'h0000_0000; vec_c[0] = 8'h00;
      vec_d[1] = 32'h0000_0001; vec_c[1] = 8'h51;
      vec_d[2] = 32'h8000_0000; vec_c[2] = 8'h8A;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, vec_d[i], 1'b1, 1'b0, 6'd0);
         chk("vec_accept", 64'(got_acc), 64'd1);
         step(1'b0, 32'h0, 1'b1, 1'b0, 6'd0);
         chk("vec_lat1_quiet", 64'(got_out), 64'd0);
         step(1'b0, 32'h0, 1'b1, 1'b0, 6'd0);
         chk("vec_lat2_out", 64'(got_out), 64'd1);
         chk("vec_check", 64'(last_chk), 64'(vec_c[i]));
      end

      for (int i = 0; i < 8; i++) begin
         step(1'b1, $urandom, 1'b1, 1'b0, 6'd0);
         chk("burst_accept", 64'(got_acc), 64'd1);
      end
      for (int c = 0; c < 20 && sb.size() != 0; c++) step(1'b0, 32'h0, 1'b1, 1'b0, 6'd0);
      chk("burst_drained", 64'(sb.size()), 64'd0);

      do_reset();
      for (int i = 0; i < 4; i++) w[i] = $urandom;
      w[4] = '0;
      idx  = 0;
      for (int c = 0; c < 5; c++) begin
         step(idx < 4, w[idx], 1'b0, 1'b0, 6'd0);
         if (got_acc) idx++;
      end
      chk("stall_in_ready", 64'(last_rdy), 64'd0);
      chk("stall_accepted", 64'(idx), 64'd2);
      for (int c = 0; c < 30 && !(idx == 4 && sb.size() == 0); c++) begin
         step(idx < 4, w[idx], 1'b1, 1'b0, 6'd0);
         if (got_acc) idx++;
      end
      chk("stall_all_sent", 64'(idx), 64'd4);
      chk("stall_drained", 64'(sb.size()), 64'd0);
      #1;
      chk("stall_word_cnt", 64'(bus.word_cnt), 64'd4);
      @(negedge clk);

      do_reset();
      step(1'b0, 32'h0, 1'b1, 1'b1, 6'd35);
      step(1'b1, 32'h0, 1'b1, 1'b0, 6'd0);
      step(1'b1, 32'h0, 1'b1, 1'b0, 6'd0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 6'd0);
      chk("inj_first_out", 64'(got_out), 64'd1);
      chk("inj_first_check", 64'(last_chk), 64'h08);
      chk("inj_busy_fall", 64'(bus.inj_busy), 64'd0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 6'd0);
      chk("inj_second_out", 64'(got_out), 64'd1);
      chk("inj_second_check", 64'(last_chk), 64'h00);

      do_reset();
      step(1'b0, 32'h0, 1'b0, 1'b1, 6'd3);
      step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 6'd0);
      step(1'b1, 32'h1234_5678, 1'b0, 1'b0, 6'd0);
      do_reset();
      #1;
      chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("midrst_word_cnt", 64'(bus.word_cnt), 64'd0);
      chk("midrst_inj_busy", 64'(bus.inj_busy), 64'd0);
      chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      step(1'b1, 32'h0000_0010, 1'b1, 1'b0, 6'd0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 6'd0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 6'd0);
      chk("midrst_post_out", 64'(got_out), 64'd1);
      chk("midrst_post_check", 64'(last_chk), 64'(ref_check(32'h0000_0010)));

      n2 = 0;
      bus2.in_valid  = 1'b1;
      bus2.out_ready = 1'b1;
      for (int c = 0; c < 14; c++) begin
         bus2.in_data = $urandom;
         #1;
         chk("sat_word_cnt", 64'(bus2.word_cnt), 64'((n2 > 7) ? 7 : n2));
         if (bus2.out_valid) n2++;
         @(negedge clk);
      end
      bus2.in_valid = 1'b0;

      do_reset();
      sent = 0;
      for (int c = 0; c < 60000 && (sent < 10000 || sb.size() != 0); c++) begin
         logic        iv, ordy, arm;
         logic [31:0] d;
         iv   = (sent < 10000) && ($urandom_range(0, 1) == 1);
         d    = $urandom;
         ordy = ($urandom_range(0, 3) != 0);
         arm  = (sb.size() == 0) && !m_busy && ($urandom_range(0, 1) == 1);
         step(iv, d, ordy, arm, 6'($urandom_range(0, 63)));
         if (got_acc) sent++;
      end
      chk("rand_remaining", 64'(sb.size() + (10000 - sent)), 64'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/sec32_encoder.md
SEC32_ENCODER -- requirements
Module: sec32_encoder

Interface
REQ-001 Parameter: CNT_W, 16, width of the encoded-word counter.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: in_valid  input  1  input word present.
REQ-005 Port: in_ready  output  1  encoder accepts the word this cycle.
REQ-006 Port: in_data  input  32  data word; d[k] is bit k.
REQ-007 Port: out_valid  output  1  codeword present.
REQ-008 Port: out_ready  input  1  sink accepts the codeword.
REQ-009 Port: out_data  output  32  data part of the codeword.
REQ-010 Port: out_check  output  8  check bits c[7:0].
REQ-011 Port: inj_arm  input  1  one-cycle pulse that arms single-bit error injection.
REQ-012 Port: inj_pos  input  6  codeword bit to flip: 0..31 data, 32..39 check c[pos-32], 40..63 no flip.
REQ-013 Port: inj_busy  output  1  injection armed and not yet applied.
REQ-014 Port: word_cnt  output  CNT_W  count of codewords delivered (out_valid and out_ready), saturating.

Function
REQ-015 Check bits SHALL be XOR reductions (Pi = parity of the listed bits):
  c0 = P(d16..d23) ^ d0^d4^d8^d12
  c1 = P(d24..d31) ^ d1^d5^d9^d13
  c2 = P(d16..d19, d24..d27) ^ d2^d6^d10^d14
  c3 = P(d20..d23, d28..d31) ^ d3^d7^d11^d15
  c4 = P(d0..d7) ^ d16^d20^d24^d28
  c5 = P(d8..d15) ^ d17^d21^d25^d29
  c6 = P(d0..d3, d8..d11) ^ d18^d22^d26^d30
  c7 = P(d4..d7, d12..d15) ^ d19^d23^d27^d31
REQ-016 The pipeline SHALL have two register stages: S1 holds data plus the eight 4-bit group parities and the eight column parities. S2 holds out_data/out_check.
REQ-017 Latency SHALL be 2 cycles from input acceptance to out_valid when no stall occurs. Throughput SHALL be one word per cycle.
REQ-018 A stage SHALL advance when it is empty or when its downstream accepts. in_ready = !S1_valid | S2_advance, with no combinational path from in_valid to in_ready.
REQ-019 While out_valid=1 and out_ready=0, out_data, out_check and out_valid SHALL hold stable and no word SHALL be dropped or duplicated.
REQ-020 Injection FSM states SHALL be IDLE, ARMED and APPLY.
  - IDLE: inj_arm moves to ARMED and latches inj_pos.
  - ARMED: the next word loaded into S2 has the latched bit flipped; the state moves to APPLY.
  - APPLY: the state returns to IDLE when that word is delivered.
REQ-021 inj_arm SHALL be ignored outside IDLE. inj_busy SHALL be 1 in ARMED and APPLY.
REQ-022 An armed injection SHALL apply to exactly one word. If inj_pos is 40..63, that word is unmodified but the FSM still passes through APPLY.
REQ-023 word_cnt SHALL increment on each out_valid&out_ready and stick at 2^CNT_W-1.

Reset
REQ-024 Reset SHALL clear S1/S2 valid, out_valid=0, out_data=0, out_check=0, word_cnt=0, FSM=IDLE and inj_busy=0. in_ready=1 in the first cycle after reset.
REQ-025 Reset mid-operation SHALL discard in-flight words and any armed injection without emitting a partial codeword.

Structure
REQ-026 A shared package SHALL hold the data width (32), check width (8), the injection-FSM state enum and the check-bit index constants.
REQ-027 One sub-module, sec32_parity (a purely combinational 32-to-8 check generator), SHALL be used. Its S1/S2 split follows REQ-016.

Verification
REQ-028 in_data=0x00000000 with out_ready=1 -> out_check=0x00 two cycles later.
REQ-029 in_data=0x00000001 -> out_check=0x51. in_data=0x80000000 -> out_check=0x8A.
REQ-030 Stream of 4 words with out_ready held 0 for 5 cycles -> in_ready=0 after S1/S2 fill, no loss, order preserved, word_cnt=4 at end.
REQ-031 Arm inj_pos=35 then send 0x00000000 twice -> first out_check=0x08, second 0x00, inj_busy falls after first delivery.
REQ-032 Assert rst while 2 words are in flight and injection is ARMED -> next cycle out_valid=0, word_cnt=0, inj_busy=0. Subsequent word encodes without flip.
REQ-033 Random data for 10^4 words -> feeding (out_data, out_check, check-enable=1) into the team's c499 SEC decoder with correct key returns in_data unchanged. A single injected bit is corrected.
